// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the unified text/data Memory.
// One single-word transaction at a time: IDLE -> ACCESS -> RESP.
module mem_arbiter #(
   parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
   parameter logic [31:0] TEXT_LIMIT = 32'h0040_1000,
   parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
   parameter logic [31:0] DATA_LIMIT = 32'h1001_1000
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic [31:0] mem_address,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   state_t state, state_nxt;
   logic   owner, owner_nxt;
   logic   last_grant, last_grant_nxt;
   txn_t   txn, txn_nxt, req_sel;
   logic   illegal, illegal_nxt;
   logic   winner;

   logic [1:0]       ack_r, err_r;
   logic [1:0][31:0] rdata_r;

   // Text is read-only to masters; both windows are base-inclusive, limit-exclusive.
   function automatic logic is_illegal(input logic [31:0] a, input logic w);
      logic in_text, in_data;
      in_text = (a >= TEXT_BASE) && (a < TEXT_LIMIT);
      in_data = (a >= DATA_BASE) && (a < DATA_LIMIT);
      return (a[1:0] != 2'b00) || !(in_text || in_data) || (w && in_text);
   endfunction

   always_comb begin
      winner = 1'b0;
      if (req0 && req1) winner = ~last_grant;
      else if (req1)    winner = 1'b1;
      req_sel = winner ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         txn        <= '0;
         illegal    <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         txn        <= txn_nxt;
         illegal    <= illegal_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      txn_nxt        = txn;
      illegal_nxt    = illegal;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt      = ACCESS;
               owner_nxt      = winner;
               last_grant_nxt = winner;
               txn_nxt        = req_sel;
               illegal_nxt    = is_illegal(req_sel.addr, req_sel.we);
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory sees only registered state, so mem_write is flat across the write negedge.
   always_comb begin
      mem_address    = '0;
      mem_write      = 1'b0;
      mem_write_data = '0;
      if (state == ACCESS) begin
         mem_address    = txn.addr;
         mem_write      = txn.we & ~illegal;
         mem_write_data = txn.wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         ack_r   <= '0;
         err_r   <= '0;
         rdata_r <= '0;
      end else if (state == ACCESS) begin
         rdata_r[owner] <= (illegal || txn.we) ? 32'h0 : mem_read_data;
         err_r[owner]   <= illegal;
         ack_r[owner]   <= 1'b1;
      end else if (state == RESP) begin
         ack_r[owner] <= 1'b0;
         err_r[owner] <= 1'b0;
      end
   end

   assign ack0   = ack_r[0];
   assign ack1   = ack_r[1];
   assign err0   = err_r[0];
   assign err1   = err_r[1];
   assign rdata0 = rdata_r[0];
   assign rdata1 = rdata_r[1];
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a window-rule / round-robin reference model.
module tb_mem_arbiter;
   localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
   localparam logic [31:0] TEXT_LIMIT = 32'h0040_1000;
   localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
   localparam logic [31:0] DATA_LIMIT = 32'h1001_1000;

   logic        clock = 1'b0;
   logic        clear, req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1, mem_write, busy;
   logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;

   logic [31:0] mem_text [1024];
   logic [31:0] mem_data [1024];
   logic [31:0] ref_text [1024];
   logic [31:0] ref_data [1024];
   logic [31:0] exp_rdata [2];
   logic        last_g;

   mem_arbiter dut (
      .clock(clock), .clear(clear),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_address(mem_address), .mem_write(mem_write),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic in_text(input logic [31:0] a);
      return (a >= TEXT_BASE) && (a < TEXT_LIMIT);
   endfunction

   function automatic logic in_data(input logic [31:0] a);
      return (a >= DATA_BASE) && (a < DATA_LIMIT);
   endfunction

   // Memory: combinational read, write on the negedge.
   assign mem_read_data = in_text(mem_address) ? mem_text[mem_address[11:2]] :
                          in_data(mem_address) ? mem_data[mem_address[11:2]] : 32'h0;

   always @(negedge clock) begin
      if (mem_write === 1'b1) begin
         wr_cnt = wr_cnt + 1;
         if (in_data(mem_address))      mem_data[mem_address[11:2]] <= mem_write_data;
         else if (in_text(mem_address)) mem_text[mem_address[11:2]] <= mem_write_data;
      end
   end

   function automatic logic model_err(input logic [31:0] a, input logic w);
      return (a % 4 != 0) || !(in_text(a) || in_data(a)) || (w && in_text(a));
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (in_text(a)) return ref_text[a[11:2]];
      if (in_data(a)) return ref_data[a[11:2]];
      return 32'h0;
   endfunction

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 6))
         0, 1:    return DATA_BASE + 4 * $urandom_range(0, 15);
         2:       return TEXT_BASE + 4 * $urandom_range(0, 15);
         3:       return DATA_BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
         4:       return ($urandom_range(0, 1) != 0) ? DATA_LIMIT : TEXT_LIMIT;
         5:       return ($urandom_range(0, 1) != 0) ? DATA_BASE - 4 : TEXT_BASE - 4;
         default: return ($urandom_range(0, 1) != 0) ? DATA_LIMIT - 4 : TEXT_LIMIT - 4;
      endcase
   endfunction

   task automatic reset_dut();
      clear = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      @(posedge clock); @(posedge clock); #1;
      clear = 1'b0;
   endtask

   // Drives one transaction and reports what was observed at its ack.
   task automatic single_txn(input int m, input logic w, input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output int wrs, output logic e, output logic [31:0] rd);
      int w0;
      w0 = wr_cnt; lat = -1; e = 1'bx; rd = 'x;
      if (m == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
      else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
      for (int c = 1; c <= 10; c++) begin
         @(posedge clock); #1;
         if (((m == 0) ? ack0 : ack1) === 1'b1) begin
            lat = c; e = (m == 0) ? err0 : err1; rd = (m == 0) ? rdata0 : rdata1;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clock); #1;
      wrs = wr_cnt - w0;
   endtask

   task automatic test_reset();
      reset_dut();
      checks++;
      if ({ack0, ack1, err0, err1, rdata0, rdata1} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got ack=%b%b err=%b%b rdata0=%h rdata1=%h exp all 0",
                  ack0, ack1, err0, err1, rdata0, rdata1);
      end
      checks++;
      if ({mem_address, mem_write, mem_write_data, busy} !== '0) begin
         failures++;
         $display("FAIL reset_mem_if got addr=%h we=%b wd=%h busy=%b exp all 0",
                  mem_address, mem_write, mem_write_data, busy);
      end
   endtask

   task automatic test_read();
      int lat, wrs; logic e; logic [31:0] rd;
      single_txn(0, 1'b0, DATA_BASE, 32'h0, lat, wrs, e, rd);
      checks++; if (lat !== 2) begin failures++; $display("FAIL read_latency got=%0d exp=2", lat); end
      checks++; if (rd !== 32'd100) begin failures++; $display("FAIL read_rdata got=%h exp=%h", rd, 32'd100); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", e); end
      checks++; if (wrs !== 0) begin failures++; $display("FAIL read_memwrite got=%0d exp=0", wrs); end
   endtask

   task automatic test_write_read();
      int lat, wrs; logic e; logic [31:0] rd;
      single_txn(1, 1'b1, DATA_BASE + 8, 32'hDEAD_BEEF, lat, wrs, e, rd);
      ref_data[2] = 32'hDEAD_BEEF;
      checks++; if (lat !== 2) begin failures++; $display("FAIL write_latency got=%0d exp=2", lat); end
      checks++; if (wrs !== 1) begin failures++; $display("FAIL write_negedges got=%0d exp=1", wrs); end
      checks++; if (e !== 1'b0 || rd !== 32'h0) begin
         failures++; $display("FAIL write_resp got err=%b rdata=%h exp err=0 rdata=0", e, rd);
      end
      single_txn(0, 1'b0, DATA_BASE + 8, 32'h0, lat, wrs, e, rd);
      checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL readback got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_text_read();
      int lat, wrs; logic e; logic [31:0] rd;
      single_txn(1, 1'b0, TEXT_BASE, 32'h0, lat, wrs, e, rd);
      checks++; if (rd !== 32'h0022_1820 || e !== 1'b0) begin
         failures++; $display("FAIL text_read got rdata=%h err=%b exp rdata=00221820 err=0", rd, e);
      end
      checks++; if (rdata0 !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL text_other_hold got rdata0=%h exp=deadbeef", rdata0);
      end
   endtask

   task automatic test_illegal();
      int          ms [3] = '{0, 1, 0};
      logic        ws [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] as [3] = '{DATA_LIMIT, TEXT_BASE, DATA_BASE + 2};
      int lat, wrs; logic e; logic [31:0] rd;
      for (int i = 0; i < 3; i++) begin
         single_txn(ms[i], ws[i], as[i], 32'h1234_5678, lat, wrs, e, rd);
         checks++;
         if (lat !== 2 || e !== 1'b1 || rd !== 32'h0 || wrs !== 0) begin
            failures++;
            $display("FAIL illegal_%0d got lat=%0d err=%b rdata=%h writes=%0d exp lat=2 err=1 rdata=0 writes=0",
                     i, lat, e, rd, wrs);
         end
      end
   endtask

   // Both masters hold req: each transaction is ACCESS, RESP, IDLE and winners alternate 0,1,...
   task automatic test_back_to_back();
      logic ea0, ea1, eb;
      int phase, t;
      reset_dut();
      req0 = 1'b1; we0 = 1'b0; addr0 = DATA_BASE + 4;
      req1 = 1'b1; we1 = 1'b0; addr1 = DATA_BASE + 8;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clock); #1;
         phase = (k - 1) % 3; t = (k - 1) / 3;
         eb = (phase != 2); ea0 = (phase == 1) && (t % 2 == 0); ea1 = (phase == 1) && (t % 2 == 1);
         checks++;
         if ({ack0, ack1, busy} !== {ea0, ea1, eb}) begin
            failures++;
            $display("FAIL b2b_cycle%0d got ack0=%b ack1=%b busy=%b exp %b %b %b", k, ack0, ack1, busy, ea0, ea1, eb);
         end
         if (ea0 || ea1) begin
            checks++;
            if ((ea0 ? rdata0 : rdata1) !== ref_read(ea0 ? addr0 : addr1)) begin
               failures++;
               $display("FAIL b2b_rdata%0d got=%h exp=%h", k, ea0 ? rdata0 : rdata1, ref_read(ea0 ? addr0 : addr1));
            end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_clear_abort();
      int first_c, second_c;
      req1 = 1'b1; we1 = 1'b0; addr1 = DATA_BASE + 4;
      @(posedge clock); #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_access got busy=%b exp=1", busy); end
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0; req1 = 1'b0;
      checks++;
      if (ack1 !== 1'b0 || busy !== 1'b0 || rdata1 !== 32'h0 || rdata0 !== 32'h0) begin
         failures++;
         $display("FAIL abort_state got ack1=%b busy=%b rdata1=%h rdata0=%h exp 0 0 0 0", ack1, busy, rdata1, rdata0);
      end
      req0 = 1'b1; we0 = 1'b0; addr0 = DATA_BASE;
      req1 = 1'b1; we1 = 1'b0; addr1 = DATA_BASE + 4;
      first_c = -1; second_c = -1;
      for (int c = 1; c <= 12 && second_c < 0; c++) begin
         @(posedge clock); #1;
         if (ack0 === 1'b1 && first_c < 0) begin first_c = c; req0 = 1'b0; end
         else if (ack1 === 1'b1) begin second_c = c; req1 = 1'b0; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++; if (first_c !== 2 || second_c !== 5) begin
         failures++; $display("FAIL abort_regrant got ack0@%0d ack1@%0d exp ack0@2 ack1@5", first_c, second_c);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_random();
      reset_dut();
      exp_rdata[0] = '0; exp_rdata[1] = '0; last_g = 1'b1;
      for (int it = 0; it < 40; it++) begin
         logic [1:0]  en, done;
         logic        tw [2];
         logic [31:0] ta [2], td [2];
         int          order [2];
         int          nexp, cyc, w0, exp_w, m;
         logic        e;
         en = 2'($urandom_range(1, 3));
         for (int k = 0; k < 2; k++) begin
            tw[k] = 1'($urandom_range(0, 1)); ta[k] = pick_addr(); td[k] = $urandom;
         end
         if (en == 2'b11) begin order[0] = last_g ? 0 : 1; order[1] = last_g ? 1 : 0; end
         else begin order[0] = en[1] ? 1 : 0; order[1] = order[0]; end
         req0 = en[0]; we0 = tw[0]; addr0 = ta[0]; wdata0 = td[0];
         req1 = en[1]; we1 = tw[1]; addr1 = ta[1]; wdata1 = td[1];
         w0 = wr_cnt; exp_w = 0; nexp = 0; done = 2'b00; cyc = 0;
         while (done != en && cyc < 12) begin
            @(posedge clock); #1; cyc++;
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
               m = order[nexp];
               e = model_err(ta[m], tw[m]);
               exp_rdata[m] = (e || tw[m]) ? 32'h0 : ref_read(ta[m]);
               if (!e && tw[m]) begin ref_data[ta[m][11:2]] = td[m]; exp_w++; end
               last_g = (m == 1);
               checks++; if ({ack1, ack0} !== ((m == 0) ? 2'b01 : 2'b10)) begin
                  failures++; $display("FAIL rnd_grant it=%0d got ack1,ack0=%b%b exp master %0d", it, ack1, ack0, m);
               end
               checks++; if (cyc !== 2 + 3 * nexp) begin
                  failures++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, cyc, 2 + 3 * nexp);
               end
               checks++; if (((m == 0) ? err0 : err1) !== e) begin
                  failures++; $display("FAIL rnd_err it=%0d addr=%h we=%b got=%b exp=%b", it, ta[m], tw[m], (m == 0) ? err0 : err1, e);
               end
               checks++; if (rdata0 !== exp_rdata[0] || rdata1 !== exp_rdata[1]) begin
                  failures++; $display("FAIL rnd_rdata it=%0d got %h %h exp %h %h", it, rdata0, rdata1, exp_rdata[0], exp_rdata[1]);
               end
               if (m == 0) req0 = 1'b0; else req1 = 1'b0;
               done[m] = 1'b1; nexp++;
            end
         end
         req0 = 1'b0; req1 = 1'b0;
         checks++; if (done !== en) begin failures++; $display("FAIL rnd_timeout it=%0d got done=%b exp=%b", it, done, en); end
         @(posedge clock); #1;
         checks++; if (wr_cnt - w0 !== exp_w) begin
            failures++; $display("FAIL rnd_writes it=%0d got=%0d exp=%0d", it, wr_cnt - w0, exp_w);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_text[i] = 32'h0022_1820 + 32'(i) * 32'h100; ref_text[i] = mem_text[i];
         mem_data[i] = 32'd100 + 32'(i) * 3;             ref_data[i] = mem_data[i];
      end
      clear = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      test_reset();
      test_read();
      test_write_read();
      test_text_read();
      test_illegal();
      test_back_to_back();
      test_clear_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single unified Memory (text window 0x00400000–0x00400FFF, data window 0x10010000–0x10010FFF) between the multicycle CPU port (master 0) and a loader/debug port (master 1). Grants one single-word transaction at a time with round-robin fairness and a req/ack handshake. Rejects illegal accesses before they reach Memory. Sits between the multicycle control/datapath and Memory.

## Interface
- TEXT_BASE, 32'h00400000, first byte of the text window
- TEXT_LIMIT, 32'h00401000, one past the last text byte
- DATA_BASE, 32'h10010000, first byte of the data window
- DATA_LIMIT, 32'h10011000, one past the last data byte
- clock  in  1  single clock; all state updates on posedge
- clear  in  1  reset, synchronous and active-high
- req0, req1  in  1  transaction request from master 0 / 1
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  32  byte address
- wdata0, wdata1  in  32  write data
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  valid with ack; 1 = access rejected
- rdata0, rdata1  out  32  read data, valid with ack; held until that master's next ack
- mem_address  out  32  to Memory address
- mem_write  out  1  to Memory write
- mem_write_data  out  32  to Memory write_data
- mem_read_data  in  32  from Memory read_data (combinational)
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, owner (0/1), last_grant, latched addr/we/wdata, illegal flag, rdata0/1, ack0/1, err0/1.
- IDLE: no req → stay. One req → grant it. Both → grant the master ≠ last_grant. On grant: owner ← winner, last_grant ← winner, latch that master's addr/we/wdata, compute illegal, → ACCESS.
- Illegal: addr[1:0] ≠ 0; or addr outside both windows; or we=1 to the text window (text is read-only to masters). Window checks are unsigned, base inclusive, limit exclusive.
- ACCESS: mem_address = latched addr. mem_write = latched we & ~illegal. mem_write_data = latched wdata. At the posedge ending ACCESS: rdata_owner ← (illegal | we) ? 0 : mem_read_data; err_owner ← illegal; ack_owner ← 1; → RESP.
- RESP: ack_owner high for exactly this cycle, then ack cleared; err_owner cleared at the same time. The other master's outputs are untouched. → IDLE.
- In IDLE and RESP: mem_address = 0, mem_write = 0, mem_write_data = 0.
- Master rule: hold req/we/addr/wdata stable until ack is seen; req may be reasserted in the cycle after ack. Input changes while not in IDLE are ignored, because the transaction uses latched values.
- clear: state ← IDLE, last_grant ← 1 (master 0 wins the first tie); ack0/1, err0/1, rdata0/1 ← 0; latched regs ← 0.

## Timing
- Reset values: all outputs 0, busy 0.
- Transaction latency: req sampled at posedge T (IDLE) → ACCESS during T..T+1 → ack high during cycle T+1..T+2. That is 3 cycles per transaction, and the next grant is no earlier than the posedge after RESP.
- mem_write is driven only from registered state. It is stable across the mid-cycle negedge on which Memory writes; exactly one negedge per legal write.
- Simultaneous reqs under continuous demand alternate 0,1,0,1.
- clear during ACCESS or RESP: the transaction is aborted with no ack. mem_write drops at that posedge; a write already committed at the preceding negedge stands.

## Test plan
- Reset, then req0 read at 0x10010000 with Memory holding 100 → ack0 at cycle 2 after req, rdata0=100, err0=0, mem_write never 1.
- req1 write 0xDEADBEEF to 0x10010008, then req0 read 0x10010008 → mem_write high exactly one ACCESS cycle; rdata0=0xDEADBEEF.
- req0 and req1 both held for 4 transactions from reset → grant order 0,1,0,1; each ack a single cycle; busy low for one cycle between transactions.
- Illegal: req0 read 0x10011000; req1 write 0x00400000; req0 read 0x10010002 → each acked with err=1, rdata=0, mem_write=0.
- Read 0x00400000 on port 1 → rdata1=0x00221820. Port 0's rdata0 is unchanged from its last ack.
- Assert clear during ACCESS of a req1 read → no ack1, busy=0 next cycle, rdata1=0; a following req0 is granted first.
